mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences data-memory accesses for the MEM stage of the rv32i pipeline.
//  - Accepts one load/store from the stage.
//  - Runs the read/write/resp handshake with the data cache.
//  - Stalls the pipeline until the access completes.
//  - Returns the aligned, extended load value plus the matching regfilemux select.
//  - Generates byte enables and shifted store data.
// PARAMETERS
//  XLEN  32  data/address width; only 32 is supported
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-low reset
//  req_valid     in   1   MEM stage holds a load or store
//  req_write     in   1   1 = store, 0 = load
//  req_funct3    in   3   000 b, 001 h, 010 w, 100 bu, 101 hu (loads only)
//  req_addr      in   32  byte address from ALU
//  req_wdata     in   32  rs2 value for stores
//  flush         in   1   squash: no new accept; suppress in-flight load_valid
//  stall         out  1   hold pipeline
//  dmem_read     out  1   read strobe
//  dmem_write    out  1   write strobe
//  dmem_address  out  32  {addr[31:2],2'b00}
//  dmem_wdata    out  32  req_wdata << 8*addr[1:0]
//  dmem_mbe      out  4   byte mask
//  dmem_rdata    in   32  read data, valid with dmem_resp
//  dmem_resp     in   1   access complete, one-cycle pulse
//  load_valid    out  1   load_data valid, one-cycle pulse
//  load_data     out  32  extracted and extended load result
//  load_sel      out  4   regfilemux code: lw 0011, lb 0101, lbu 0110, lh 0111, lhu 1000; store 0000
//  access_err    out  1   misaligned or illegal funct3 (combinational)
// BEHAVIOUR
//  - Reset: state IDLE; all registered outputs 0; strobes drop asynchronously mid-access.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE, accept: req_valid & !flush & legal & aligned in cycle T.
//    - Capture addr, funct3, write and wdata at T.
//    - State becomes ACCESS at T+1.
//    - req_* changes after T are ignored.
//  - ACCESS:
//    - dmem_read or dmem_write = 1, registered, from T+1 through the cycle dmem_resp=1 inclusive.
//    - address, mbe and wdata are constant for the whole access.
//    - dmem_resp in the first strobe cycle is valid.
//    - On resp: capture dmem_rdata and go to DONE.
//    - Strobes are 0 in the next cycle.
//  - DONE:
//    - Exactly one cycle; stall=0.
//    - load_valid=1 iff the access was a load and no flush was seen since accept.
//    - Then return to IDLE.
//  - stall = req_valid & !flush & !access_err & (state != DONE); combinational.
//    - Minimum stall is 2 cycles: T, then T+1 with an immediate resp.
//  - Alignment:
//    - h/hu require addr[0]=0; w requires addr[1:0]=0; b is always aligned.
//    - Illegal funct3: load 011/110/111; store other than 000/001/010.
//  - access_err = req_valid & state==IDLE & (misaligned | illegal).
//    - stall=0 in that case; no memory access is issued.
//  - Byte mask:
//    - Store: sb 0001<<a, sh 0011<<a, sw 1111, where a = addr[1:0].
//    - Load: mbe=1111.
//  - Load extract: v = rdata >> 8*a.
//    - lb sext v[7:0]; lbu zext v[7:0]; lh sext v[15:0]; lhu zext v[15:0]; lw rdata.
//  - load_data and load_sel are held from DONE until the next accept; load_sel is 0 after reset.
//  - flush during ACCESS: the access still completes (no cache abort); load_valid is suppressed; stall is 0 while flush=1.
//  - dmem_resp outside ACCESS is ignored.
//  - Back-to-back ops: the next request can be accepted in the cycle after DONE.
// TESTING
//  - Reset 0 mid-ACCESS -> dmem_read/dmem_write fall the same cycle; all outputs 0.
//  - lw addr 0x100, resp after 3 cycles with rdata 0xDEADBEEF -> address 0x100, mbe 1111; stall 4 cycles; load_valid 1 cycle; load_data 0xDEADBEEF; load_sel 0011.
//  - lb addr 0x103, rdata 0x80xxxxxx -> load_data 0xFFFFFF80; lbu same address -> 0x00000080, load_sel 0110.
//  - sh addr 0x202, wdata 0x1234ABCD -> address 0x200, mbe 1100, dmem_wdata 0xABCD0000, dmem_write held until resp.
//  - lw addr 0x101 -> access_err=1, stall=0, no strobe; sh addr 0x3 -> same.
//  - lh issued, flush pulse during ACCESS -> resp is consumed, load_valid stays 0, FSM returns to IDLE.
//  - Immediate resp on the first strobe cycle, then a new sw in the following IDLE -> accepted; two distinct accesses, no lost resp.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Load/store bundle between the MEM stage, the controller and the data cache.
// The slave modport is the controller's view; the master modport is the environment's view.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        load_valid;
  logic [31:0] load_data;
  logic [3:0]  load_sel;
  logic        access_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, flush,
    output dmem_rdata, dmem_resp,
    input  stall, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  load_valid, load_data, load_sel, access_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, flush,
    input  dmem_rdata, dmem_resp,
    output stall, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output load_valid, load_data, load_sel, access_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache sequencer: one load/store per IDLE->ACCESS->DONE pass, strobes held until resp.
// Stalls the pipeline from accept through the resp cycle (minimum 2 cycles); flush releases stall and drops load_valid.
module mem_access_ctrl #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [1:0]        a_q;
  logic              flushed_q;
  logic              rd_q, wr_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [3:0]        mbe_q;
  logic              lv_q;
  logic [XLEN-1:0]   ld_q;
  logic [3:0]        sel_q;

  logic [1:0]        a;
  logic              illegal, misaligned, accept;
  logic [3:0]        mbe_d;
  logic [XLEN-1:0]   shifted, ext;

  assign a = bus.req_addr[1:0];

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (bus.req_write)
      illegal = !(bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b001 ||
                  bus.req_funct3 == 3'b010);
    else
      illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    if (bus.req_funct3[1:0] == 2'b01) misaligned = a[0];
    if (bus.req_funct3[1:0] == 2'b10) misaligned = (a != 2'b00);
  end

  assign bus.access_err = bus.req_valid & (state_q == IDLE) & (misaligned | illegal);
  assign accept         = bus.req_valid & !bus.flush & (state_q == IDLE) & !(misaligned | illegal);
  assign bus.stall      = bus.req_valid & !bus.flush & !bus.access_err & (state_q != DONE);

  always_comb begin
    mbe_d = 4'b1111;
    if (bus.req_write) begin
      case (bus.req_funct3)
        3'b000:  mbe_d = 4'b0001 << a;
        3'b001:  mbe_d = 4'b0011 << a;
        default: mbe_d = 4'b1111;
      endcase
    end
  end

  // lw is always word aligned, so the shifted word is the raw word for it.
  assign shifted = bus.dmem_rdata >> {a_q, 3'b000};

  always_comb begin
    ext = shifted;
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  function automatic logic [3:0] sel_of(input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'b0101;
      3'b001:  return 4'b0111;
      3'b010:  return 4'b0011;
      3'b100:  return 4'b0110;
      3'b101:  return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      f3_q      <= 3'b000;
      a_q       <= 2'b00;
      flushed_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mbe_q     <= 4'b0000;
      lv_q      <= 1'b0;
      ld_q      <= '0;
      sel_q     <= 4'b0000;
    end else begin
      lv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= ACCESS;
            write_q   <= bus.req_write;
            f3_q      <= bus.req_funct3;
            a_q       <= a;
            flushed_q <= 1'b0;
            rd_q      <= !bus.req_write;
            wr_q      <= bus.req_write;
            addr_q    <= {bus.req_addr[31:2], 2'b00};
            wdata_q   <= bus.req_wdata << {a, 3'b000};
            mbe_q     <= mbe_d;
          end
        end
        ACCESS: begin
          if (bus.flush) flushed_q <= 1'b1;
          if (bus.dmem_resp) begin
            state_q <= DONE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            lv_q    <= !write_q & !flushed_q & !bus.flush;
            sel_q   <= write_q ? 4'b0000 : sel_of(f3_q);
            if (!write_q) ld_q <= ext;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dmem_read    = rd_q;
  assign bus.dmem_write   = wr_q;
  assign bus.dmem_address = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.dmem_mbe     = mbe_q;
  assign bus.load_valid   = lv_q;
  assign bus.load_data    = ld_q;
  assign bus.load_sel     = sel_q;

endmodule
